sram_block_mover: RTL

- Initiator-side engine for the 256 x 8 single-port data SRAM. It drives Address, SRAMRead, SRAMWrite and Datain, and it samples the SRAM's combinational Dataout.
- Executes byte-block FILL, COPY (memmove-safe) and optional CHECKSUM commands issued by the CPU/control path over a start/busy/done handshake.
- Sits between the control path and the SRAM. It is the only SRAM master while busy.

---
 rtl/sram_block_mover_if.sv | 48 ++++
 rtl/sram_block_mover.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/sram_block_mover_if.sv
// ---------------------------------------------------------------------------
// sram_block_mover_if
//   Groups the command handshake and the SRAM bus of sram_block_mover.
//
//   Command side : start, op, src, dst, len, pattern  -> engine
//                  busy, done, err, result            <- engine
//   SRAM side    : Address, SRAMRead, SRAMWrite, Datain <- engine
//                  Dataout (combinational SRAM read data) -> engine
//
//   Handshake: start is sampled only while busy=0. An accepted start raises
//   busy on the next cycle; busy stays high through the final cycle, in which
//   done pulses for exactly one cycle. A start seen while busy=1 is dropped,
//   never queued. Command fields only need to be valid in the accepting cycle.
//
//   Modports:
//     master - the engine (serves commands, masters the SRAM bus)
//     slave  - the environment (control path issuing commands + the SRAM)
// ---------------------------------------------------------------------------
interface sram_block_mover_if #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 8
);
    logic              start;
    logic [1:0]        op;
    logic [ADDR_W-1:0] src;
    logic [ADDR_W-1:0] dst;
    logic [ADDR_W-1:0] len;
    logic [DATA_W-1:0] pattern;
    logic              busy;
    logic              done;
    logic              err;
    logic [DATA_W-1:0] result;
    logic [ADDR_W-1:0] Address;
    logic              SRAMRead;
    logic              SRAMWrite;
    logic [DATA_W-1:0] Datain;
    logic [DATA_W-1:0] Dataout;

    modport master (
        input  start, op, src, dst, len, pattern, Dataout,
        output busy, done, err, result, Address, SRAMRead, SRAMWrite, Datain
    );

    modport slave (
        output start, op, src, dst, len, pattern, Dataout,
        input  busy, done, err, result, Address, SRAMRead, SRAMWrite, Datain
    );
endinterface

// File: rtl/sram_block_mover.sv
// ---------------------------------------------------------------------------
// sram_block_mover
//   Block FILL / COPY (memmove-safe) / optional CHECKSUM engine mastering a
//   2^ADDR_W x DATA_W single-port SRAM with combinational read data.
//
//   Ports:
//     clk         : clock, all state on posedge
//     Reset_n     : asynchronous active-low reset
//     bus         : sram_block_mover_if.master (command handshake + SRAM bus)
//     o_dbg_state : current FSM state encoding (debug observation)
//
//   Optional feature macro: SRAM_MOVER_CSUM_EN
//     defined   -> op=10 runs CHECKSUM, result is live
//     undefined -> CS_RD state and summing removed, op=10 is illegal,
//                  result tied to 0
// ---------------------------------------------------------------------------
module sram_block_mover #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 8
) (
    input  logic                 clk,
    input  logic                 Reset_n,
    sram_block_mover_if.master   bus,
    output logic [2:0]           o_dbg_state
);

    localparam logic [1:0] OP_FILL = 2'b00;
    localparam logic [1:0] OP_COPY = 2'b01;
`ifdef SRAM_MOVER_CSUM_EN
    localparam logic [1:0] OP_CSUM = 2'b10;
`endif

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_FILL_WR = 3'd1,
        S_CP_RD   = 3'd2,
        S_CP_WR   = 3'd3,
`ifdef SRAM_MOVER_CSUM_EN
        S_CS_RD   = 3'd4,
`endif
        S_DONE    = 3'd5
    } state_t;

    state_t            r_state;
    state_t            w_next;

    logic [ADDR_W-1:0] r_src_ptr;
    logic [ADDR_W-1:0] r_dst_ptr;
    logic [ADDR_W-1:0] r_rem;
    logic [ADDR_W-1:0] r_last_addr;
    logic [DATA_W-1:0] r_pattern;
    logic [DATA_W-1:0] r_hold;
    logic [DATA_W-1:0] r_last_data;
    logic              r_desc;
    logic              r_err;

    logic              w_rd;
    logic              w_wr;
    logic [ADDR_W-1:0] w_addr;
    logic [DATA_W-1:0] w_din;
    logic              w_illegal;
    logic              w_desc;
    logic              w_last;
    logic [ADDR_W-1:0] w_diff;
    logic [ADDR_W-1:0] w_step;

`ifdef SRAM_MOVER_CSUM_EN
    logic [DATA_W-1:0] r_sum;
    logic [DATA_W-1:0] r_result;
    logic [DATA_W-1:0] w_sum_next;

    assign w_illegal  = (bus.op == 2'b11);
    assign w_sum_next = r_sum + bus.Dataout;
    assign bus.result = r_result;
`else
    assign w_illegal  = bus.op[1];
    assign bus.result = '0;
`endif

    // Overlap test for memmove: only when the destination lies inside the
    // source window (modular distance) would an ascending copy clobber
    // source bytes before they are read.
    assign w_diff = bus.dst - bus.src;
    assign w_desc = (bus.op == OP_COPY) && (bus.dst != bus.src) && (w_diff < bus.len);
    assign w_last = (r_rem == ADDR_W'(1));
    assign w_step = r_desc ? '1 : ADDR_W'(1);

    // State register
    always_ff @(posedge clk or negedge Reset_n) begin
        if (!Reset_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next state and SRAM bus. Outside access states Address/Datain replay
    // the last driven value so the bus holds steady.
    always_comb begin
        w_next = r_state;
        w_rd   = 1'b0;
        w_wr   = 1'b0;
        w_addr = r_last_addr;
        w_din  = r_last_data;
        case (r_state)
            S_IDLE: begin
                if (bus.start) begin
                    if (w_illegal || (bus.len == '0)) begin
                        w_next = S_DONE;
                    end else begin
                        case (bus.op)
                            OP_FILL: w_next = S_FILL_WR;
                            OP_COPY: w_next = S_CP_RD;
`ifdef SRAM_MOVER_CSUM_EN
                            OP_CSUM: w_next = S_CS_RD;
`endif
                            default: w_next = S_DONE;
                        endcase
                    end
                end
            end
            S_FILL_WR: begin
                w_wr   = 1'b1;
                w_addr = r_dst_ptr;
                w_din  = r_pattern;
                if (w_last) w_next = S_DONE;
            end
            S_CP_RD: begin
                w_rd   = 1'b1;
                w_addr = r_src_ptr;
                w_next = S_CP_WR;
            end
            S_CP_WR: begin
                w_wr   = 1'b1;
                w_addr = r_dst_ptr;
                w_din  = r_hold;
                w_next = w_last ? S_DONE : S_CP_RD;
            end
`ifdef SRAM_MOVER_CSUM_EN
            S_CS_RD: begin
                w_rd   = 1'b1;
                w_addr = r_src_ptr;
                if (w_last) w_next = S_DONE;
            end
`endif
            S_DONE: begin
                w_next = S_IDLE;
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    // Datapath: pointers, remaining count, copy hold byte, sum.
    always_ff @(posedge clk or negedge Reset_n) begin
        if (!Reset_n) begin
            r_src_ptr   <= '0;
            r_dst_ptr   <= '0;
            r_rem       <= '0;
            r_last_addr <= '0;
            r_pattern   <= '0;
            r_hold      <= '0;
            r_last_data <= '0;
            r_desc      <= 1'b0;
            r_err       <= 1'b0;
`ifdef SRAM_MOVER_CSUM_EN
            r_sum       <= '0;
            r_result    <= '0;
`endif
        end else begin
            r_last_addr <= w_addr;
            r_last_data <= w_din;
            case (r_state)
                S_IDLE: begin
                    if (bus.start) begin
                        r_err     <= w_illegal;
                        r_rem     <= bus.len;
                        r_pattern <= bus.pattern;
                        r_desc    <= w_desc;
                        // Descending copies start at the top byte of each block.
                        r_src_ptr <= w_desc ? (bus.src + bus.len - ADDR_W'(1)) : bus.src;
                        r_dst_ptr <= w_desc ? (bus.dst + bus.len - ADDR_W'(1)) : bus.dst;
`ifdef SRAM_MOVER_CSUM_EN
                        r_sum     <= '0;
`endif
                    end
                end
                S_FILL_WR: begin
                    r_dst_ptr <= r_dst_ptr + ADDR_W'(1);
                    r_rem     <= r_rem - ADDR_W'(1);
                end
                S_CP_RD: begin
                    r_hold <= bus.Dataout;
                end
                S_CP_WR: begin
                    r_src_ptr <= r_src_ptr + w_step;
                    r_dst_ptr <= r_dst_ptr + w_step;
                    r_rem     <= r_rem - ADDR_W'(1);
                end
`ifdef SRAM_MOVER_CSUM_EN
                S_CS_RD: begin
                    r_src_ptr <= r_src_ptr + ADDR_W'(1);
                    r_rem     <= r_rem - ADDR_W'(1);
                    r_sum     <= w_sum_next;
                    if (w_last) r_result <= w_sum_next;
                end
`endif
                default: begin
                end
            endcase
        end
    end

    assign bus.busy      = (r_state != S_IDLE);
    assign bus.done      = (r_state == S_DONE);
    assign bus.err       = r_err;
    assign bus.Address   = w_addr;
    assign bus.SRAMRead  = w_rd;
    assign bus.SRAMWrite = w_wr;
    assign bus.Datain    = w_din;
    assign o_dbg_state   = r_state;

endmodule
